// File: rtl/controle_busca_instrucao_if.sv
// Bus between the fetch controller and its loader, instruction memory and datapath.
// slave = controller side, master = environment side.
interface controle_busca_instrucao_if #(
  parameter int ADDR_W = 10
);
  logic              carga_valida;
  logic [31:0]       carga_dado;
  logic              carga_fim;
  logic              carga_pronta;
  logic              erro_carga;
  logic [31:0]       mem_endereco;
  logic [31:0]       mem_dado_escrita;
  logic              mem_escrita_en;
  logic [31:0]       mem_instrucao;
  logic              parar;
  logic              desvio_valido;
  logic [ADDR_W-1:0] desvio_alvo;
  logic [31:0]       instr_saida;
  logic [ADDR_W-1:0] pc_saida;
  logic              instr_valida;
  logic              parado;

  modport slave (
    input  carga_valida, carga_dado, carga_fim, mem_instrucao,
           parar, desvio_valido, desvio_alvo,
    output carga_pronta, erro_carga, mem_endereco, mem_dado_escrita,
           mem_escrita_en, instr_saida, pc_saida, instr_valida, parado
  );

  modport master (
    output carga_valida, carga_dado, carga_fim, mem_instrucao,
           parar, desvio_valido, desvio_alvo,
    input  carga_pronta, erro_carga, mem_endereco, mem_dado_escrita,
           mem_escrita_en, instr_saida, pc_saida, instr_valida, parado
  );
endinterface

// File: rtl/controle_busca_instrucao.sv
// Instruction fetch sequencer: owns the memory write port for the program loader,
// then fetches/issues one word per cycle, resolving jump and halt locally.
//
// state   | meaning
// CARGA   | loader writes words from CARGA_BASE upward
// EXECUTA | fetch at pc, issue to datapath, take branches/jumps
// PARADO  | halted by OP_HALT, left only by reset
module controle_busca_instrucao #(
  parameter int ADDR_W     = 10,
  parameter int MEM_PROF   = 141,
  parameter int PC_INICIAL = 1,
  parameter int CARGA_BASE = 1,
  parameter int OP_JUMP    = 16,
  parameter int OP_HALT    = 18
) (
  input logic                     clock,
  input logic                     reset,
  controle_busca_instrucao_if.slave bus
);

  typedef enum logic [1:0] {CARGA, EXECUTA, PARADO} estado_t;

  localparam logic [ADDR_W-1:0] LP_PROF  = ADDR_W'(MEM_PROF);
  localparam logic [ADDR_W-1:0] LP_PC0   = ADDR_W'(PC_INICIAL);
  localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(CARGA_BASE);
  localparam logic [ADDR_W-1:0] LP_UM    = ADDR_W'(1);
  localparam logic [4:0]        LP_JUMP  = 5'(OP_JUMP);
  localparam logic [4:0]        LP_HALT  = 5'(OP_HALT);

  estado_t           r_estado, w_estado_prox;
  logic [ADDR_W-1:0] r_pc, w_pc_prox;
  logic [ADDR_W-1:0] r_ptr, w_ptr_prox;
  logic [31:0]       r_instr, w_instr_prox;
  logic [ADDR_W-1:0] r_pc_saida, w_pc_saida_prox;
  logic              r_valida, w_valida_prox;
  logic              r_parado, w_parado_prox;
  logic              r_erro, w_erro_prox;

  logic              w_pronta;
  logic              w_aceita;
  logic [4:0]        w_opcode;
  logic [ADDR_W-1:0] w_endereco;
  logic              w_unused;

  // Gated by reset so a word presented during reset is never written.
  assign w_pronta   = (r_estado == CARGA) && (r_ptr < LP_PROF) && !reset;
  assign w_aceita   = bus.carga_valida && w_pronta;
  assign w_opcode   = bus.mem_instrucao[31:27];
  assign w_endereco = (r_estado == CARGA) ? r_ptr : r_pc;
  assign w_unused   = ^bus.mem_instrucao[26:ADDR_W];

  assign bus.carga_pronta     = w_pronta;
  assign bus.mem_escrita_en   = w_aceita;
  assign bus.mem_dado_escrita = bus.carga_dado;
  assign bus.mem_endereco     = {{(32-ADDR_W){1'b0}}, w_endereco};
  assign bus.erro_carga       = r_erro;
  assign bus.instr_saida      = r_instr;
  assign bus.pc_saida         = r_pc_saida;
  assign bus.instr_valida     = r_valida;
  assign bus.parado           = r_parado;

  always_comb begin
    w_estado_prox   = r_estado;
    w_pc_prox       = r_pc;
    w_ptr_prox      = r_ptr;
    w_instr_prox    = r_instr;
    w_pc_saida_prox = r_pc_saida;
    w_valida_prox   = r_valida;
    w_parado_prox   = r_parado;
    w_erro_prox     = r_erro;
    case (r_estado)
      CARGA: begin
        w_valida_prox = 1'b0;
        if (w_aceita)
          w_ptr_prox = r_ptr + LP_UM;
        else if (bus.carga_valida)
          w_erro_prox = 1'b1;
        if (bus.carga_fim)
          w_estado_prox = EXECUTA;
      end
      EXECUTA: begin
        if (bus.desvio_valido) begin
          w_pc_prox     = bus.desvio_alvo;
          w_valida_prox = 1'b0;
        end else if (bus.parar) begin
          w_pc_prox = r_pc;
        end else if (w_opcode == LP_JUMP) begin
          w_pc_prox     = bus.mem_instrucao[ADDR_W-1:0];
          w_valida_prox = 1'b0;
        end else if (w_opcode == LP_HALT) begin
          w_estado_prox = PARADO;
          w_parado_prox = 1'b1;
          w_valida_prox = 1'b0;
        end else begin
          w_instr_prox    = bus.mem_instrucao;
          w_pc_saida_prox = r_pc;
          w_valida_prox   = 1'b1;
          w_pc_prox       = r_pc + LP_UM;
        end
      end
      PARADO: begin
        w_valida_prox = 1'b0;
        w_parado_prox = 1'b1;
      end
      default: w_estado_prox = CARGA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= CARGA;
      r_pc       <= LP_PC0;
      r_ptr      <= LP_BASE;
      r_instr    <= '0;
      r_pc_saida <= '0;
      r_valida   <= 1'b0;
      r_parado   <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      r_estado   <= w_estado_prox;
      r_pc       <= w_pc_prox;
      r_ptr      <= w_ptr_prox;
      r_instr    <= w_instr_prox;
      r_pc_saida <= w_pc_saida_prox;
      r_valida   <= w_valida_prox;
      r_parado   <= w_parado_prox;
      r_erro     <= w_erro_prox;
    end
  end

endmodule
